// File: rtl/wb_pipelined_ram.sv
// Purpose: Wishbone pipelined-mode 32-bit RAM with byte lanes and an in-order, fixed-latency response pipe.
// Latency: LATENCY cycles from the acceptance edge to the single-cycle ack/err.
// Backpressure: stall is raised while MAX_OUT requests are outstanding and none retires this cycle.
module wb_pipelined_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter int          MAX_OUT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
  localparam logic [2:0]  MAX_CNT   = 3'(MAX_OUT);

  logic [31:0]        mem [DEPTH];
  logic [29:0]        word_off;
  logic               in_range;
  logic [AW-1:0]      idx;
  logic               acc;
  logic               resp;
  logic               unused_adr;

  // One pipe stage per latency cycle; the tail stage is the response presented this cycle.
  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_err;
  logic [LATENCY-1:0] pipe_rd;
  logic [31:0]        pipe_dat [LATENCY];

  logic [2:0]         count;
  logic [2:0]         count_nxt;

  // Decode is done on word addresses so the ignored byte offset never enters the range check.
  assign word_off   = adr[31:2] - BASE_WORD;
  assign in_range   = (adr[31:2] >= BASE_WORD) && (word_off < DEPTH_W);
  assign idx        = word_off[AW-1:0];
  assign unused_adr = ^adr[1:0];

  // Nothing is accepted while reset is held, so no write can sneak in during reset.
  assign acc  = rst_n & cyc & stb & ~stall;
  assign resp = cyc & pipe_vld[LATENCY-1];

  // Byte-lane writes land at the acceptance edge; contents survive reset and cyc drops.
  always_ff @(posedge clk) begin
    if (acc && we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          mem[idx][8*i +: 8] <= dat_i[8*i +: 8];
        end
      end
    end
  end

  // Response pipe: stage 0 captures the request outcome (and read data) at acceptance, then shifts; cyc low flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      pipe_rd  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else if (!cyc) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= acc;
      pipe_err[0] <= acc & ~in_range;
      pipe_rd[0]  <= acc & ~we & in_range;
      pipe_dat[0] <= (acc && !we && in_range) ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_rd[i]  <= pipe_rd[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  // Outstanding count: acceptance and retirement in the same cycle cancel; a dropped cyc clears it.
  always_comb begin
    count_nxt = count;
    if (!cyc) begin
      count_nxt = '0;
    end else if (acc && !resp) begin
      count_nxt = count + 3'd1;
    end else if (!acc && resp) begin
      count_nxt = count - 3'd1;
    end
  end

  // Registered outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Termination decode and stall, combinational on the pipe tail and the registered count.
  always_comb begin
    ack   = resp & ~pipe_err[LATENCY-1];
    err   = resp & pipe_err[LATENCY-1];
    dat_o = (ack && pipe_rd[LATENCY-1]) ? pipe_dat[LATENCY-1] : '0;
    stall = (count == MAX_CNT) & ~resp;
  end

endmodule

// File: tb/tb_wb_pipelined_ram.sv
// Bench for wb_pipelined_ram: instance A (LATENCY=2, MAX_OUT=2, BASE 0x1000, 64 words) and
// instance B (LATENCY=3, MAX_OUT=1, BASE 0, 16 words). A directed vector table, hand sequences
// and a random run; instance A is shadowed by a queue-based transaction model throughout.
module tb_wb_pipelined_ram;

  localparam logic [31:0] BASE_A  = 32'h0000_1000;
  localparam int          DEPTH_A = 64;
  localparam int          LAT_A   = 2;
  localparam int          MAX_A   = 2;
  localparam logic [31:0] END_A   = BASE_A + 4 * DEPTH_A;

  logic clk;
  logic rst_n;

  logic        a_cyc, a_stb, a_we, a_ack, a_err, a_stall;
  logic [31:0] a_adr, a_dati, a_dato;
  logic [3:0]  a_sel;
  logic        b_cyc, b_stb, b_we, b_ack, b_err, b_stall;
  logic [31:0] b_adr, b_dati, b_dato;
  logic [3:0]  b_sel;

  int total = 0;
  int bad   = 0;

  wb_pipelined_ram #(.BASE_ADDR(BASE_A), .DEPTH(DEPTH_A), .LATENCY(LAT_A), .MAX_OUT(MAX_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .cyc(a_cyc), .stb(a_stb), .we(a_we), .adr(a_adr), .sel(a_sel),
    .dat_i(a_dati), .dat_o(a_dato), .ack(a_ack), .err(a_err), .stall(a_stall));

  wb_pipelined_ram #(.BASE_ADDR(32'h0), .DEPTH(16), .LATENCY(3), .MAX_OUT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cyc(b_cyc), .stb(b_stb), .we(b_we), .adr(b_adr), .sel(b_sel),
    .dat_i(b_dati), .dat_o(b_dato), .ack(b_ack), .err(b_err), .stall(b_stall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model of instance A: pending responses with their due cycle, plus a word array.
  typedef struct {
    int          due;
    bit          is_err;
    bit          is_rd;
    logic [31:0] dat;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem_a [DEPTH_A];
  int          cyc_no = 0;

  typedef struct {
    bit          c, s, w;
    logic [31:0] a;
    logic [3:0]  sl;
    logic [31:0] d;
    bit          e_ack, e_err;
    logic [31:0] e_dat;
    bit          e_stall;
  } vec_t;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic vec_t mk(bit c, bit s, bit w, logic [31:0] a, logic [3:0] sl, logic [31:0] d,
                              bit ea, bit ee, logic [31:0] ed, bit es);
    vec_t v;
    v.c = c; v.s = s; v.w = w; v.a = a; v.sl = sl; v.d = d;
    v.e_ack = ea; v.e_err = ee; v.e_dat = ed; v.e_stall = es;
    return v;
  endfunction

  // One bus cycle on instance A, entered and left at posedge+1; outputs sampled at the negedge.
  task automatic step_a(input bit c, input bit s, input bit w, input logic [31:0] a,
                        input logic [3:0] sl, input logic [31:0] d,
                        output logic o_ack, output logic o_err, output logic [31:0] o_dat,
                        output logic o_stall);
    bit          resp, e_ack, e_err, e_stall, acc, inr;
    logic [31:0] e_dat, aw;
    int          idx;
    rsp_t        r;
    a_cyc = c; a_stb = s; a_we = w; a_adr = a; a_sel = sl; a_dati = d;
    @(negedge clk);
    resp  = c && (q.size() > 0) && (q[0].due == cyc_no);
    e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
    if (resp) begin
      e_ack = !q[0].is_err;
      e_err = q[0].is_err;
      e_dat = (e_ack && q[0].is_rd) ? q[0].dat : 32'h0;
    end
    e_stall = (q.size() == MAX_A) && !resp;
    o_ack = a_ack; o_err = a_err; o_dat = a_dato; o_stall = a_stall;
    chk("mdl_ack", a_ack, e_ack);
    chk("mdl_err", a_err, e_err);
    chk("mdl_dat", a_dato, e_dat);
    chk("mdl_stall", a_stall, e_stall);
    acc = c && s && !e_stall;
    @(posedge clk);
    if (!c) begin
      q.delete();
    end else begin
      if (resp) void'(q.pop_front());
      if (acc) begin
        aw  = a & ~32'd3;
        inr = (aw >= BASE_A) && (aw < END_A);
        r.due = cyc_no + LAT_A; r.is_err = !inr; r.is_rd = inr && !w; r.dat = 32'h0;
        if (inr) begin
          idx = int'((aw - BASE_A) / 4);
          if (!w) r.dat = mem_a[idx];
          else for (int i = 0; i < 4; i++) if (sl[i]) mem_a[idx][8*i +: 8] = d[8*i +: 8];
        end
        q.push_back(r);
      end
    end
    cyc_no++;
    #1;
  endtask

  // One bus cycle on instance B with explicit expectations; stall check optional.
  task automatic step_b(input string nm, input bit c, input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit ea, input bit ee, input logic [31:0] ed,
                        input bit es, input bit cs);
    b_cyc = c; b_stb = s; b_we = w; b_adr = a; b_sel = 4'hF; b_dati = d;
    @(negedge clk);
    chk({nm, "_ack"}, b_ack, ea);
    chk({nm, "_err"}, b_err, ee);
    chk({nm, "_dat"}, b_dato, ed);
    if (cs) chk({nm, "_stall"}, b_stall, es);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[37];
    logic        oa, oe, os;
    logic [31:0] od, ra;
    int          r;

    tv[0]  = mk(1,1,1, 32'h1008, 4'hF, 32'hDEADBEEF, 0,0,32'h0,0);
    tv[1]  = mk(1,1,0, 32'h1008, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[2]  = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0,0);
    tv[3]  = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'hDEADBEEF,0);
    tv[4]  = mk(1,1,1, 32'h1010, 4'hF, 32'h11223344, 0,0,32'h0,0);
    tv[5]  = mk(1,1,1, 32'h1010, 4'h5, 32'hAABBCCDD, 0,0,32'h0,0);
    tv[6]  = mk(1,1,0, 32'h1010, 4'hF, 32'h0,        1,0,32'h0,0);
    tv[7]  = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0,0);
    tv[8]  = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h11BB33DD,0);
    tv[9]  = mk(1,1,1, 32'h1000, 4'hF, 32'h0A0B0C0D, 0,0,32'h0,0);
    tv[10] = mk(1,1,1, 32'h1004, 4'hF, 32'h5555AAAA, 0,0,32'h0,0);
    tv[11] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0,0);
    tv[12] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0,0);
    tv[13] = mk(1,1,1, 32'h1000, 4'h0, 32'hFFFFFFFF, 0,0,32'h0,0);
    tv[14] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,0,32'h0,0);
    tv[15] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0,0);
    tv[16] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,0,32'h0,0);
    tv[17] = mk(1,1,0, 32'h1000, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[18] = mk(1,1,0, 32'h1004, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[19] = mk(1,1,0, 32'h1008, 4'hF, 32'h0,        1,0,32'h0A0B0C0D,0);
    tv[20] = mk(1,1,0, 32'h1010, 4'hF, 32'h0,        1,0,32'h5555AAAA,0);
    tv[21] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'hDEADBEEF,0);
    tv[22] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h11BB33DD,0);
    tv[23] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,0,32'h0,0);
    tv[24] = mk(1,1,0, 32'h1100, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[25] = mk(1,1,0, 32'h1004, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[26] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,1,32'h0,0);
    tv[27] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h5555AAAA,0);
    tv[28] = mk(1,1,1, 32'h1100, 4'hF, 32'h12345678, 0,0,32'h0,0);
    tv[29] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,0,32'h0,0);
    tv[30] = mk(1,1,0, 32'h1000, 4'hF, 32'h0,        0,1,32'h0,0);
    tv[31] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,0,32'h0,0);
    tv[32] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0A0B0C0D,0);
    tv[33] = mk(0,1,1, 32'h1000, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[34] = mk(1,1,0, 32'h1003, 4'hF, 32'h0,        0,0,32'h0,0);
    tv[35] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        0,0,32'h0,0);
    tv[36] = mk(1,0,0, 32'h0,    4'h0, 32'h0,        1,0,32'h0A0B0C0D,0);

    rst_n = 1'b1;
    a_cyc = 0; a_stb = 0; a_we = 0; a_adr = 0; a_sel = 0; a_dati = 0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = 0; b_sel = 0; b_dati = 0;
    #3 rst_n = 1'b0;
    #2;
    chk("rst_a_ack", a_ack, 0);   chk("rst_a_err", a_err, 0);
    chk("rst_a_stall", a_stall, 0); chk("rst_a_dat", a_dato, 0);
    chk("rst_b_ack", b_ack, 0);   chk("rst_b_err", b_err, 0);
    chk("rst_b_stall", b_stall, 0); chk("rst_b_dat", b_dato, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word of instance A so random reads always have defined contents.
    for (int i = 0; i < DEPTH_A; i++) step_a(1, 1, 1, BASE_A + 4 * i, 4'hF, $urandom, oa, oe, od, os);
    repeat (3) step_a(1, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);

    // Directed vectors.
    for (int i = 0; i < 37; i++) begin
      step_a(tv[i].c, tv[i].s, tv[i].w, tv[i].a, tv[i].sl, tv[i].d, oa, oe, od, os);
      chk($sformatf("tv%0d_ack", i), oa, tv[i].e_ack);
      chk($sformatf("tv%0d_err", i), oe, tv[i].e_err);
      chk($sformatf("tv%0d_dat", i), od, tv[i].e_dat);
      chk($sformatf("tv%0d_stall", i), os, tv[i].e_stall);
    end

    // cyc dropped one cycle after two acceptances: both responses vanish.
    step_a(1, 1, 0, 32'h1008, 4'hF, 32'h0, oa, oe, od, os);
    step_a(1, 1, 0, 32'h1010, 4'hF, 32'h0, oa, oe, od, os);
    step_a(0, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);
    chk("drop_c2_ack", oa, 0); chk("drop_c2_err", oe, 0);
    for (int i = 3; i < 5; i++) begin
      step_a(1, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);
      chk($sformatf("drop_c%0d_ack", i), oa, 0);
      chk($sformatf("drop_c%0d_err", i), oe, 0);
      chk($sformatf("drop_c%0d_stall", i), os, 0);
    end

    // Reset pulse with two reads in flight.
    step_a(1, 1, 0, 32'h1000, 4'hF, 32'h0, oa, oe, od, os);
    step_a(1, 1, 0, 32'h1004, 4'hF, 32'h0, oa, oe, od, os);
    a_stb = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rmid_ack", a_ack, 0); chk("rmid_err", a_err, 0);
    chk("rmid_stall", a_stall, 0); chk("rmid_dat", a_dato, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rmid_hold_ack", a_ack, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step_a(1, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);
      chk($sformatf("rpost%0d_ack", i), oa, 0);
      chk($sformatf("rpost%0d_err", i), oe, 0);
      chk($sformatf("rpost%0d_stall", i), os, 0);
    end
    step_a(1, 1, 0, 32'h1008, 4'hF, 32'h0, oa, oe, od, os);
    step_a(1, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);
    step_a(1, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);
    chk("rkeep_ack", oa, 1); chk("rkeep_dat", od, 32'hDEADBEEF);
    step_a(1, 0, 0, 32'h0, 4'h0, 32'h0, oa, oe, od, os);
    a_cyc = 1'b0;

    // Instance B: LATENCY=3, MAX_OUT=1, two back-to-back requests.
    step_b("b_n0", 1,1,1, 32'h8, 32'hCAFEF00D, 0,0,32'h0,0,1);
    step_b("b_n1", 1,1,0, 32'h8, 32'h0,        0,0,32'h0,1,1);
    step_b("b_n2", 1,1,0, 32'h8, 32'h0,        0,0,32'h0,1,1);
    step_b("b_n3", 1,1,0, 32'h8, 32'h0,        1,0,32'h0,0,1);
    step_b("b_n4", 1,0,0, 32'h0, 32'h0,        0,0,32'h0,1,1);
    step_b("b_n5", 1,0,0, 32'h0, 32'h0,        0,0,32'h0,1,1);
    step_b("b_n6", 1,0,0, 32'h0, 32'h0,        1,0,32'hCAFEF00D,0,1);
    step_b("b_n7", 1,0,0, 32'h0, 32'h0,        0,0,32'h0,0,1);
    // Out-of-range read on B.
    step_b("b_oor0", 1,1,0, 32'h40, 32'h0, 0,0,32'h0,0,1);
    step_b("b_oor1", 1,0,0, 32'h0,  32'h0, 0,0,32'h0,1,1);
    step_b("b_oor2", 1,0,0, 32'h0,  32'h0, 0,0,32'h0,1,1);
    step_b("b_oor3", 1,0,0, 32'h0,  32'h0, 0,1,32'h0,0,1);
    step_b("b_oor4", 1,0,0, 32'h0,  32'h0, 0,0,32'h0,0,1);
    // cyc drop on B clears the count so the next request is not stalled.
    step_b("b_drop0", 1,1,0, 32'h8, 32'h0, 0,0,32'h0,0,1);
    step_b("b_drop1", 0,0,0, 32'h0, 32'h0, 0,0,32'h0,0,0);
    step_b("b_drop2", 1,0,0, 32'h0, 32'h0, 0,0,32'h0,0,1);
    step_b("b_drop3", 1,1,0, 32'h8, 32'h0, 0,0,32'h0,0,1);
    step_b("b_drop4", 1,0,0, 32'h0, 32'h0, 0,0,32'h0,1,1);
    step_b("b_drop5", 1,0,0, 32'h0, 32'h0, 0,0,32'h0,1,1);
    step_b("b_drop6", 1,0,0, 32'h0, 32'h0, 1,0,32'hCAFEF00D,0,1);
    step_b("b_drop7", 1,0,0, 32'h0, 32'h0, 0,0,32'h0,0,1);
    b_cyc = 1'b0;

    // Random traffic on A against the model.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0)      ra = BASE_A - 32'd4 + 32'($urandom_range(0, 3));
      else if (r == 1) ra = END_A + 32'($urandom_range(0, 3));
      else if (r == 2) ra = $urandom;
      else             ra = BASE_A + 32'(4 * $urandom_range(0, DEPTH_A - 1)) + 32'($urandom_range(0, 3));
      step_a($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
             ra, 4'($urandom_range(0, 15)), $urandom, oa, oe, od, os);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_pipelined_ram.md
WB_PIPELINED_RAM -- requirements
Module: wb_pipelined_ram

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-002 SHALL provide parameter DEPTH, default 1024, memory size in 32-bit words (power of two, 2..65536).
REQ-003 SHALL provide parameter LATENCY, default 2, cycles from request acceptance to response (legal 1..4).
REQ-004 SHALL provide parameter MAX_OUT, default 2, maximum outstanding accepted-but-unanswered requests (legal 1..4).
REQ-005 SHALL have one clock and asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 cyc  in  1  Wishbone cycle.
REQ-007 stb  in  1  Wishbone strobe.
REQ-008 we  in  1  write enable.
REQ-009 adr  in  32  byte address; adr[1:0] ignored.
REQ-010 sel  in  4  byte-lane selects, sel[i] = bits 8i+7:8i.
REQ-011 dat_i  in  32  write data.
REQ-012 dat_o  out  32  read data.
REQ-013 ack  out  1  normal termination.
REQ-014 err  out  1  error termination.
REQ-015 stall  out  1  pipeline stall.

Function
REQ-016 Acceptance SHALL occur at a rising edge where cyc & stb & !stall.
REQ-017 In range SHALL mean BASE_ADDR <= adr < BASE_ADDR + 4*DEPTH; word index = (adr - BASE_ADDR) >> 2.
REQ-018 An accepted in-range write SHALL update the enabled byte lanes at the acceptance edge; sel = 0 SHALL write nothing but still be acked.
REQ-019 An accepted in-range read SHALL capture the memory word at acceptance, reflecting all writes accepted at earlier edges.
REQ-020 Request accepted at end of cycle n SHALL get exactly one response (ack or err) asserted for one cycle in cycle n+LATENCY.
REQ-021 Responses SHALL be returned in acceptance order; back-to-back acceptances SHALL yield responses in consecutive cycles.
REQ-022 An out-of-range request SHALL respond with err (ack low, dat_o 0) and SHALL NOT modify memory.
REQ-023 ack and err SHALL never be high simultaneously.
REQ-024 dat_o SHALL carry read data only in a read-ack cycle and SHALL be 0 in every other cycle, including write acks.
REQ-025 An outstanding counter SHALL be kept: +1 per acceptance, -1 per response, both in one cycle leaving it unchanged.
REQ-026 stall SHALL equal (count == MAX_OUT) & !(response in current cycle); combinational on the registered count.
REQ-027 With MAX_OUT >= LATENCY, continuous requests SHALL be accepted every cycle with stall never asserted.
REQ-028 With MAX_OUT < LATENCY, stall SHALL rise once MAX_OUT requests are outstanding and fall in the cycle the oldest response is asserted.
REQ-029 If cyc is low in a cycle, no ack/err SHALL be asserted that cycle, and at that edge all in-flight entries SHALL be discarded and the count cleared; completed writes persist.
REQ-030 stb without cyc SHALL be ignored.
REQ-031 Count SHALL never exceed MAX_OUT and never underflow.

Reset
REQ-032 While rst_n is low: ack=0, err=0, stall=0, dat_o=0, count=0, all pipeline entries invalid, asynchronously.
REQ-033 Memory contents SHALL NOT be reset; deassertion SHALL take effect at the first rising clk edge after rst_n rises.
REQ-034 Reset asserted mid-transaction SHALL discard all in-flight responses; none SHALL appear after release.

Verification
REQ-035 Write 32'hDEADBEEF to BASE_ADDR+8 (sel=4'hF), read back, LATENCY=2 -> ack 2 cycles after each acceptance, read dat_o=32'hDEADBEEF.
REQ-036 Write 32'h11223344 then sel=4'b0101 write 32'hAABBCCDD same address, read -> dat_o=32'h11BB33DD.
REQ-037 Four back-to-back reads, LATENCY=2, MAX_OUT=2 -> stall never high, four acks in four consecutive cycles, data in order.
REQ-038 LATENCY=3, MAX_OUT=1, two back-to-back requests -> stall high cycles n+1..n+2, second accepted end of n+3, ack in n+3 and n+6.
REQ-039 Read BASE_ADDR+4*DEPTH, then in-range read -> err in n+LATENCY, ack next cycle, no memory change.
REQ-040 Drop cyc one cycle after two acceptances; also pulse rst_n low mid-flight -> no ack/err for discarded entries, count 0, stall 0, memory retains earlier writes.
